// File: rtl/dma_window_responder_if.sv
// dma_window_responder_if: request, RAM and filter-buffer signals of the DMA window responder
interface dma_window_responder_if #(
  parameter int WIN = 5,
  parameter int AW = 16,
  parameter int DW = 16
);
  logic start, finish;
  logic [AW-1:0] start_address;
  logic [15:0] offset;
  logic [1:0] read_write_filter_bias;
  logic [15:0] filter_number;
  logic signed [DW-1:0] input_data;
  logic [WIN*WIN*DW-1:0] output_data;
  logic mem_enable, mem_write;
  logic [AW-1:0] mem_address;
  logic signed [DW-1:0] mem_wdata, mem_rdata;
  logic mem_done;
  logic fb_write;
  logic [WIN*WIN*DW-1:0] fb_filter;
  logic fb_bias_write;
  logic signed [DW-1:0] fb_bias;
  logic [15:0] fb_index;
  logic err;
  modport master (
    output start, start_address, offset, read_write_filter_bias, filter_number, input_data, mem_rdata, mem_done,
    input finish, output_data, mem_enable, mem_write, mem_address, mem_wdata, fb_write, fb_filter, fb_bias_write, fb_bias, fb_index, err
  );
  modport slave (
    input start, start_address, offset, read_write_filter_bias, filter_number, input_data, mem_rdata, mem_done,
    output finish, output_data, mem_enable, mem_write, mem_address, mem_wdata, fb_write, fb_filter, fb_bias_write, fb_bias, fb_index, err
  );
endinterface

// File: rtl/dma_window_responder.sv
// dma_window_responder: sequences RAM word accesses for window reads, word writes, filter and bias loads.
// Define DMA_RSP_BOUNDS_CHECK_EN to reject requests whose last address overflows AW bits.
module dma_window_responder #(
  parameter int WIN = 5,
  parameter int AW = 16,
  parameter int DW = 16
) (
  input logic clk,
  input logic reset,
  dma_window_responder_if.slave bus
);
  localparam int N = WIN * WIN;
  localparam int CW = $clog2(WIN);
  localparam logic [CW-1:0] LAST = CW'(WIN - 1);
  typedef enum logic [2:0] {IDLE, ACCESS, GAP, EMIT, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] r_q, r_d, c_q, c_d;
  logic [1:0] mode_q, mode_d, req_mode;
  logic [15:0] off_q, off_d, fn_q, fn_d, k_q, k_d, fb_index_q, fb_index_d;
  logic [AW-1:0] addr_q, addr_d, row_q, row_d, kb_q, kb_d;
  logic [DW-1:0] wdata_q, wdata_d, fb_bias_q, fb_bias_d;
  logic [N*DW-1:0] out_q, out_d, filt_q, filt_d;
  logic en_q, en_d, wr_q, wr_d, finish_q, finish_d, fbw_q, fbw_d, fbb_q, fbb_d;
  logic last_col, win_end, bias_end, ovf;
  int idx;
  assign req_mode = bus.read_write_filter_bias;
  assign last_col = c_q == LAST;
  assign win_end = last_col && r_q == LAST;
  assign bias_end = k_q + 16'd1 == fn_q;
  assign idx = int'(r_q) * WIN + int'(c_q);
`ifdef DMA_RSP_BOUNDS_CHECK_EN
  localparam int LW = AW + 24;
  logic [LW-1:0] last_addr;
  logic err_q, err_d;
  always_comb begin
    last_addr = LW'(bus.start_address);
    if (!req_mode[0]) last_addr = last_addr + LW'(WIN - 1) * LW'(bus.offset) + LW'(WIN - 1);
    if (req_mode == 2'd2) last_addr = last_addr + LW'(bus.filter_number - 16'd1) * LW'(N);
    if (req_mode == 2'd3) last_addr = last_addr + LW'(bus.filter_number - 16'd1);
    ovf = |last_addr[LW-1:AW] && !(req_mode[1] && bus.filter_number == 16'd0);
    err_d = state_q == IDLE && bus.start ? ovf : err_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else err_q <= err_d;
  end
  assign bus.err = err_q;
`else
  assign ovf = 1'b0;
  assign bus.err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    r_d = r_q;
    c_d = c_q;
    mode_d = mode_q;
    off_d = off_q;
    fn_d = fn_q;
    k_d = k_q;
    fb_index_d = fb_index_q;
    addr_d = addr_q;
    row_d = row_q;
    kb_d = kb_q;
    wdata_d = wdata_q;
    fb_bias_d = fb_bias_q;
    out_d = out_q;
    filt_d = filt_q;
    en_d = en_q;
    wr_d = wr_q;
    finish_d = finish_q;
    fbw_d = 1'b0;
    fbb_d = 1'b0;
    if (state_q == IDLE) begin
      if (bus.start) begin
        mode_d = req_mode;
        off_d = bus.offset;
        fn_d = bus.filter_number;
        wdata_d = bus.input_data;
        addr_d = bus.start_address;
        row_d = bus.start_address;
        kb_d = bus.start_address;
        r_d = '0;
        c_d = '0;
        k_d = '0;
        if ((req_mode[1] && bus.filter_number == 16'd0) || ovf) begin
          state_d = DONE;
          finish_d = 1'b1;
        end else begin
          state_d = ACCESS;
          en_d = 1'b1;
          wr_d = req_mode == 2'd1;
        end
      end
    end else if (state_q == ACCESS) begin
      if (bus.mem_done) begin
        en_d = 1'b0;
        wr_d = 1'b0;
        state_d = GAP;
        if (mode_q == 2'd1) begin
          state_d = DONE;
          finish_d = 1'b1;
        end else if (mode_q == 2'd3) begin
          fbb_d = 1'b1;
          fb_bias_d = bus.mem_rdata;
          fb_index_d = k_q;
          k_d = k_q + 16'd1;
          addr_d = addr_q + 1'b1;
          state_d = bias_end ? DONE : GAP;
          finish_d = bias_end;
        end else begin
          if (!mode_q[1]) out_d[idx*DW +: DW] = bus.mem_rdata;
          else filt_d[idx*DW +: DW] = bus.mem_rdata;
          c_d = last_col ? '0 : c_q + 1'b1;
          r_d = last_col ? (win_end ? '0 : r_q + 1'b1) : r_q;
          row_d = last_col ? row_q + AW'(off_q) : row_q;
          addr_d = last_col ? row_q + AW'(off_q) : addr_q + 1'b1;
          // Next kernel starts N words after this one, independent of the row stride
          if (win_end) begin
            kb_d = kb_q + AW'(N);
            row_d = kb_q + AW'(N);
            addr_d = kb_q + AW'(N);
            state_d = mode_q[1] ? EMIT : DONE;
            finish_d = !mode_q[1];
            fbw_d = mode_q[1];
            fb_index_d = mode_q[1] ? k_q : fb_index_q;
          end
        end
      end
    end else if (state_q == GAP) begin
      state_d = ACCESS;
      en_d = 1'b1;
    end else if (state_q == EMIT) begin
      k_d = k_q + 16'd1;
      state_d = bias_end ? DONE : GAP;
      finish_d = bias_end;
    end else if (!bus.start) begin
      state_d = IDLE;
      finish_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      r_q <= '0;
      c_q <= '0;
      mode_q <= '0;
      off_q <= '0;
      fn_q <= '0;
      k_q <= '0;
      fb_index_q <= '0;
      addr_q <= '0;
      row_q <= '0;
      kb_q <= '0;
      wdata_q <= '0;
      fb_bias_q <= '0;
      out_q <= '0;
      filt_q <= '0;
      en_q <= 1'b0;
      wr_q <= 1'b0;
      finish_q <= 1'b0;
      fbw_q <= 1'b0;
      fbb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q <= r_d;
      c_q <= c_d;
      mode_q <= mode_d;
      off_q <= off_d;
      fn_q <= fn_d;
      k_q <= k_d;
      fb_index_q <= fb_index_d;
      addr_q <= addr_d;
      row_q <= row_d;
      kb_q <= kb_d;
      wdata_q <= wdata_d;
      fb_bias_q <= fb_bias_d;
      out_q <= out_d;
      filt_q <= filt_d;
      en_q <= en_d;
      wr_q <= wr_d;
      finish_q <= finish_d;
      fbw_q <= fbw_d;
      fbb_q <= fbb_d;
    end
  end
  assign bus.finish = finish_q;
  assign bus.output_data = out_q;
  assign bus.mem_enable = en_q;
  assign bus.mem_write = wr_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.fb_write = fbw_q;
  assign bus.fb_filter = filt_q;
  assign bus.fb_bias_write = fbb_q;
  assign bus.fb_bias = fb_bias_q;
  assign bus.fb_index = fb_index_q;
endmodule

// File: tb/tb_dma_window_responder.sv
// tb_dma_window_responder: directed requests against a fixed-latency RAM model; expected
// fb pulses and finish results are queued at issue and checked by an independent monitor.
module tb_dma_window_responder;
  localparam int WIN = 5;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int N = WIN * WIN;
  localparam int NW = N * DW;
  localparam int L = 2;
  typedef struct {
    int kind;
    int idx;
    logic [NW-1:0] data;
    logic err;
    bit wchk;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int tests = 0;
  int failed = 0;
  int rises = 0;
  int accesses = 0;
  int cnt = 0;
  logic en_prev = 1'b0;
  logic fin_prev = 1'b0;
  logic [15:0] ram [0:65535];
  exp_t q[$];

  dma_window_responder_if #(.WIN(WIN), .AW(AW), .DW(DW)) bus ();
  dma_window_responder #(.WIN(WIN), .AW(AW), .DW(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!bus.mem_enable || bus.mem_done) begin
      bus.mem_done <= 1'b0;
      cnt <= 0;
    end else if (cnt == L - 2) begin
      bus.mem_done <= 1'b1;
      cnt <= 0;
      accesses++;
      if (bus.mem_write) ram[bus.mem_address] <= bus.mem_wdata;
      else bus.mem_rdata <= ram[bus.mem_address];
    end else cnt <= cnt + 1;
  end

  task automatic chk(input string nm, input logic [NW-1:0] got, input logic [NW-1:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  task automatic chki(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      failed++;
      $display("FAIL %s: got %0d, required %0d", nm, got, exp);
    end
  endtask

  task automatic sb(input int kind, input logic [15:0] idx, input logic [NW-1:0] data, input logic e);
    exp_t x;
    tests++;
    if (q.size() == 0) begin
      failed++;
      $display("FAIL sb_unexpected: got event kind %0d idx %0d, required no event", kind, idx);
    end else begin
      x = q.pop_front();
      if (x.kind != kind || (kind != 1 && x.idx != int'(idx)) || ((kind != 1 || x.wchk) && x.data !== data) || (kind == 1 && x.err !== e)) begin
        failed++;
        $display("FAIL sb_kind%0d: got idx %0d err %0b data %h, required kind %0d idx %0d err %0b data %h",
                 kind, idx, e, data, x.kind, x.idx, x.err, x.data);
      end
    end
  endtask

  function automatic void push(input int kind, input int idx, input logic [NW-1:0] data, input logic e, input bit wchk);
    exp_t x;
    x.kind = kind;
    x.idx = idx;
    x.data = data;
    x.err = e;
    x.wchk = wchk;
    q.push_back(x);
  endfunction

  function automatic logic [NW-1:0] win(input logic [15:0] base, input logic [15:0] off);
    logic [NW-1:0] w;
    w = '0;
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++)
        w[(r*WIN+c)*DW +: DW] = base + 16'(r) * off + 16'(c);
    return w;
  endfunction

  function automatic logic [NW-1:0] word(input logic [15:0] v);
    logic [NW-1:0] w;
    w = '0;
    w[DW-1:0] = v;
    return w;
  endfunction

  always @(negedge clk) begin
    if (bus.mem_enable && !en_prev) rises++;
    en_prev = bus.mem_enable;
    if (bus.fb_write) sb(2, bus.fb_index, bus.fb_filter, 1'b0);
    if (bus.fb_bias_write) sb(3, bus.fb_index, {{(N-1)*DW{1'b0}}, bus.fb_bias}, 1'b0);
    if (bus.finish && !fin_prev) sb(1, 16'd0, bus.output_data, bus.err);
    fin_prev = bus.finish;
  end

  task automatic run(input logic [1:0] m, input logic [15:0] sa, input logic [15:0] off,
                     input logic [15:0] fn, input logic [15:0] din, output int cyc);
    @(posedge clk);
    #1;
    bus.read_write_filter_bias = m;
    bus.start_address = sa;
    bus.offset = off;
    bus.filter_number = fn;
    bus.input_data = din;
    bus.start = 1'b1;
    cyc = 0;
    while (!bus.finish && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 3) begin
        bus.start_address = ~sa;
        bus.offset = off + 16'd7;
        bus.filter_number = fn + 16'd1;
        bus.input_data = ~din;
      end
    end
    chki("finish_seen", int'(bus.finish), 1);
    repeat (3) @(posedge clk);
    #1;
    chki("finish_held", int'(bus.finish), 1);
    chki("no_retrigger", int'(bus.mem_enable), 0);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chki("finish_cleared", int'(bus.finish), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required $finish");
    $fatal(1);
  end

  initial begin
    int cyc, r0, a0;
    for (int a = 0; a < 65536; a++) ram[a] = 16'(a);
    bus.start = 1'b0;
    bus.start_address = '0;
    bus.offset = '0;
    bus.read_write_filter_bias = '0;
    bus.filter_number = '0;
    bus.input_data = '0;
    #2 reset = 1'b1;
    #1;
    chki("rst_finish", int'(bus.finish), 0);
    chk("rst_mem", NW'({bus.mem_enable, bus.mem_write, bus.mem_address, bus.mem_wdata}), '0);
    chk("rst_output_data", bus.output_data, '0);
    chk("rst_fb", NW'({bus.fb_write, bus.fb_bias_write, bus.fb_bias, bus.fb_index, bus.err}), '0);
    chk("rst_fb_filter", bus.fb_filter, '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    r0 = rises;
    push(1, 0, win(16'd200, 16'd28), 1'b0, 1'b1);
    run(2'd0, 16'd200, 16'd28, 16'd0, 16'd0, cyc);
    chki("m0_latency", cyc, 25 * (L + 1));
    chki("m0_rises", rises - r0, 25);
    chk("m0_elem_4_4", word(bus.output_data[24*DW +: DW]), word(16'd316));

    a0 = accesses;
    push(1, 0, '0, 1'b0, 1'b0);
    run(2'd1, 16'd250, 16'd0, 16'd0, 16'hFFF9, cyc);
    chki("m1_ram", int'(ram[250]), 32'hFFF9);
    chki("m1_accesses", accesses - a0, 1);

    r0 = rises;
    for (int k = 0; k < 3; k++) push(2, k, win(16'(150 + 25 * k), 16'd5), 1'b0, 1'b0);
    push(1, 0, '0, 1'b0, 1'b0);
    run(2'd2, 16'd150, 16'd5, 16'd3, 16'd0, cyc);
    chki("m2_rises", rises - r0, 75);
    chki("m2_latency", cyc, 3 * (25 * (L + 1) + 1));
    chk("m2_k2_4_4", word(bus.fb_filter[24*DW +: DW]), word(16'd224));

    r0 = rises;
    for (int k = 0; k < 6; k++) push(3, k, word(16'(50550 + k)), 1'b0, 1'b0);
    push(1, 0, '0, 1'b0, 1'b0);
    run(2'd3, 16'd50550, 16'd0, 16'd6, 16'd0, cyc);
    chki("m3_rises", rises - r0, 6);

    a0 = accesses;
    push(1, 0, '0, 1'b0, 1'b0);
    run(2'd3, 16'd100, 16'd0, 16'd0, 16'd0, cyc);
    chki("m3_fn0_latency", cyc, 1);
    push(1, 0, '0, 1'b0, 1'b0);
    run(2'd2, 16'd100, 16'd5, 16'd0, 16'd0, cyc);
    chki("fn0_accesses", accesses - a0, 0);

    r0 = rises;
    push(2, 0, win(16'd150, 16'd5), 1'b0, 1'b0);
    @(posedge clk);
    #1;
    bus.read_write_filter_bias = 2'd2;
    bus.start_address = 16'd150;
    bus.offset = 16'd5;
    bus.filter_number = 16'd3;
    bus.start = 1'b1;
    cyc = 0;
    while (rises - r0 < 36 && cyc < 2000) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chki("rst_mid_reached", rises - r0, 36);
    reset = 1'b1;
    #1;
    chki("rst_mid_enable", int'(bus.mem_enable), 0);
    chki("rst_mid_finish", int'(bus.finish), 0);
    chki("rst_mid_fb_write", int'(bus.fb_write), 0);
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chki("rst_mid_sb_drained", q.size(), 0);
    push(1, 0, win(16'd1000, 16'd3), 1'b0, 1'b1);
    run(2'd0, 16'd1000, 16'd3, 16'd0, 16'd0, cyc);
    chki("rst_mid_fresh_latency", cyc, 25 * (L + 1));

    a0 = accesses;
`ifdef DMA_RSP_BOUNDS_CHECK_EN
    push(1, 0, '0, 1'b1, 1'b0);
    run(2'd0, 16'd65530, 16'd28, 16'd0, 16'd0, cyc);
    chki("bnd_accesses", accesses - a0, 0);
    chki("bnd_err_held", int'(bus.err), 1);
    push(3, 0, word(16'd10), 1'b0, 1'b0);
    push(1, 0, '0, 1'b0, 1'b0);
    run(2'd3, 16'd10, 16'd0, 16'd1, 16'd0, cyc);
    chki("bnd_err_clear", int'(bus.err), 0);
`else
    push(1, 0, win(16'd65530, 16'd28), 1'b0, 1'b1);
    run(2'd0, 16'd65530, 16'd28, 16'd0, 16'd0, cyc);
    chki("wrap_accesses", accesses - a0, 25);
    chki("wrap_err", int'(bus.err), 0);
`endif

    repeat (2) @(posedge clk);
    chki("sb_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
